// File: rtl/rv32_types.sv
// Shared types for the Zicsr execute path: CSR ids, op encodings, sequencer states,
// the write request sent to the CSR bank and the new-value ALU.
package rv32_types;

   typedef logic [11:0] rv_csr_id_t;

   // Encoding matches funct3[1:0] of the Zicsr instructions
   typedef enum logic [1:0] {
      CSR_RW = 2'b01,
      CSR_RS = 2'b10,
      CSR_RC = 2'b11
   } csr_op_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } csr_unit_state_t;

   typedef struct packed {
      logic        write;
      rv_csr_id_t  id;
      logic [31:0] value;
   } csr_write_request_t;

   function automatic logic csr_is_readonly(rv_csr_id_t id);
      return id[11:10] == 2'b11;
   endfunction

   function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old, logic [31:0] src);
      case (op)
         CSR_RS:  return old | src;
         CSR_RC:  return old & ~src;
         default: return src;
      endcase
   endfunction

endpackage

// File: rtl/rv32_csr_unit.sv
// Zicsr sequencer: accepts one CSR op, reads the old value from the bank, issues at most
// one write pulse, then holds the old value for rd writeback until it is accepted.
module rv32_csr_unit
   import rv32_types::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic               req_use_imm,
   input  logic [4:0]         req_zimm,
   input  logic [4:0]         req_rs1_idx,
   input  logic [31:0]        req_rs1_value,
   input  logic [4:0]         req_rd,
   input  logic [11:0]        req_csr_id,
   input  logic               flush,
   output logic [11:0]        csr_read_id,
   input  logic [31:0]        csr_read_value,
   output csr_write_request_t csr_write_req,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [4:0]         resp_rd,
   output logic [31:0]        resp_value,
   output logic               resp_illegal,
   output logic               busy
);

   csr_unit_state_t state_q;
   logic [1:0]      op_q;
   logic [31:0]     src_q;
   logic [31:0]     old_q;
   logic [4:0]      rd_q;
   rv_csr_id_t      id_q;
   logic            suppress_q;
   logic            illegal_q;

   logic [31:0]     src_d;
   logic            suppress_d;
   logic            illegal_d;

   // Set/clear with a zero source never writes; a read-only CSR is only illegal if a write would happen
   always_comb begin
      src_d      = req_use_imm ? {27'd0, req_zimm} : req_rs1_value;
      suppress_d = (csr_op_t'(req_op) != CSR_RW) &&
                   (req_use_imm ? (req_zimm == 5'd0) : (req_rs1_idx == 5'd0));
      illegal_d  = csr_is_readonly(req_csr_id) && !suppress_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         op_q       <= 2'b00;
         src_q      <= 32'd0;
         old_q      <= 32'd0;
         rd_q       <= 5'd0;
         id_q       <= 12'd0;
         suppress_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && !flush) begin
                  op_q       <= req_op;
                  src_q      <= src_d;
                  rd_q       <= req_rd;
                  id_q       <= req_csr_id;
                  suppress_q <= suppress_d;
                  illegal_q  <= illegal_d;
                  state_q    <= READ;
               end
            end
            READ: begin
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  old_q   <= csr_read_value;
                  state_q <= WRITE;
               end
            end
            // Once past READ the op is committed, so flush is no longer observed
            WRITE:   state_q <= RESP;
            RESP:    if (resp_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready           = (state_q == IDLE);
      busy                = (state_q != IDLE);
      csr_read_id         = id_q;
      csr_write_req.write = (state_q == WRITE) && !suppress_q && !illegal_q;
      csr_write_req.id    = id_q;
      csr_write_req.value = csr_apply(csr_op_t'(op_q), old_q, src_q);
      resp_valid          = (state_q == RESP);
      resp_rd             = rd_q;
      resp_value          = illegal_q ? 32'd0 : old_q;
      resp_illegal        = illegal_q;
   end

endmodule
